mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multicycle main control unit for the MIPS8 core; successor of the fixed 3-state sequencer.
//  Walks fetch (FETCH_BYTES byte-wide beats), decode and per-opcode execute/writeback states.
//  Emits datapath select/enable strobes and stalls on a memory ready handshake.
//  Sits between the instruction register opcode field and the datapath/memory.
// PARAMETERS
//  FETCH_BYTES  4  instruction bytes fetched per instruction, one per memory beat (legal 1..4)
//  OP_W         6  opcode field width; opcode constants below are zero-extended to OP_W
//  MEM_HS       1  1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-low reset
//  op         in   OP_W         opcode from instruction register, valid in DECODE
//  zero       in   1            ALU zero flag, sampled combinationally in BEQEX
//  mem_ready  in   1            memory beat completes this cycle
//  mem_req    out  1            memory access in progress (FETCHk, MEMRD, MEMWR)
//  memwrite   out  1            memory write strobe
//  irwrite    out  FETCH_BYTES  one-hot IR byte-lane write enable
//  pcen       out  1            PC register enable = pcwrite | (branch & zero)
//  iord       out  1            0: address=PC, 1: address=ALUOut
//  alusrca    out  1            0: PC, 1: register A
//  alusrcb    out  2            00 B, 01 const 1, 10 imm, 11 imm (branch offset)
//  aluop      out  2            00 add, 01 sub, 10 funct-decoded
//  pcsrc      out  2            00 ALU result, 01 ALUOut, 10 jump target
//  regwrite   out  1            register file write enable
//  regdst     out  1            0: rt, 1: rd
//  memtoreg   out  1            0: ALUOut, 1: memory data
//  illegal_op out  1            one-cycle pulse, undefined opcode decoded
// BEHAVIOUR
//  States: FETCH (with beat counter k=0..FETCH_BYTES-1), DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
//   RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX, ILLEGAL.
//  Reset low (async): state=FETCH, k=0; while reset low all write enables (memwrite, irwrite,
//   pcen, regwrite), mem_req and illegal_op are 0. Reset mid-instruction abandons it, no writes.
//  Outputs Moore-decoded from state except pcen (uses zero) and mem_ready-gated strobes.
//  Unlisted outputs are 0 in every state.
//  FETCH k: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00;
//   irwrite[k] and pcwrite =mem_ready; on mem_ready k++, after k=FETCH_BYTES-1 -> DECODE, k=0.
//   If !mem_ready: hold state and k, no strobes.
//  DECODE: alusrca=0, alusrcb=11, aluop=00. Next by op: 0x20 LB/0x28 SB -> MEMADR,
//   0x00 -> RTYPEEX, 0x04 -> BEQEX, 0x08 -> ADDIEX, 0x02 -> JEX, else ILLEGAL.
//  MEMADR: alusrca=1, alusrcb=10 -> MEMRD if op=0x20, MEMWR if op=0x28.
//  MEMRD: mem_req=1, iord=1; advance to MEMWB on mem_ready.
//  MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
//  MEMWR: mem_req=1, iord=1, memwrite=1 held until mem_ready; then -> FETCH.
//  RTYPEEX: alusrca=1, alusrcb=00, aluop=10 -> RTYPEWB (regwrite=1, regdst=1) -> FETCH.
//  BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 (pcen=zero) -> FETCH.
//  ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB (regwrite=1, regdst=0) -> FETCH.
//  JEX: pcsrc=10, pcwrite=1 -> FETCH.  ILLEGAL: illegal_op=1, no writes -> FETCH.
//  Unreachable state encodings -> FETCH, k=0. MEM_HS=0: every memory state is one cycle.
//  Latency (no wait): LB 4+FETCH_BYTES, SB 3+FETCH_BYTES, R/ADDI 3+FETCH_BYTES, BEQ/J 2+FETCH_BYTES.
// TESTING
//  FETCH_BYTES=4, mem_ready=1, op=0x00: irwrite 0001,0010,0100,1000 with pcen=1 each, then
//   DECODE, RTYPEEX (aluop=10), RTYPEWB regwrite=1 regdst=1, FETCH: 7 cycles total.
//  LB op=0x20, mem_ready low 3 cycles in MEMRD: mem_req=1, iord=1 held 4 cycles, MEMWB
//   memtoreg=1 regwrite=1 exactly once.
//  BEQ op=0x04: zero=1 -> pcen=1, pcsrc=01 in BEQEX; repeat with zero=0 -> pcen=0.
//  op=0x3F in DECODE -> illegal_op high one cycle, no regwrite/memwrite/pcen, then FETCH k=0.
//  reset low asserted in MEMWR with mem_ready=0: memwrite drops immediately (async),
//   after release state=FETCH k=0, irwrite[0] on first mem_ready.
//  FETCH_BYTES=1, MEM_HS=0, op=0x02: FETCH, DECODE, JEX (pcsrc=10, pcen=1), FETCH: 3 cycles.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle main control FSM for the MIPS8 core: byte-wide instruction fetch,
// decode and per-opcode execute/writeback states, stalling on memory ready.
module mips_multicycle_ctrl #(
    parameter int FETCH_BYTES = 4,
    parameter int OP_W        = 6,
    parameter int MEM_HS      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OP_W-1:0]        op,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   memwrite,
    output logic [FETCH_BYTES-1:0] irwrite,
    output logic                   pcen,
    output logic                   iord,
    output logic                   alusrca,
    output logic [1:0]             alusrcb,
    output logic [1:0]             aluop,
    output logic [1:0]             pcsrc,
    output logic                   regwrite,
    output logic                   regdst,
    output logic                   memtoreg,
    output logic                   illegal_op
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'('h00);
    localparam logic [OP_W-1:0] OP_J     = OP_W'('h02);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'('h04);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'('h08);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'('h20);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'('h28);
    localparam logic [1:0]      K_LAST   = 2'(FETCH_BYTES - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPEEX,
        S_RTYPEWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_ILLEGAL
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] k_reg, k_next;
    logic       rdy;
    logic       pcwrite;
    logic       branch;
    logic       fetch_strobe;

    // Without the handshake every memory beat completes in one cycle.
    assign rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        case (state_reg)
            S_FETCH: begin
                if (rdy) begin
                    if (k_reg == K_LAST) begin
                        state_next = S_DECODE;
                        k_next     = '0;
                    end else begin
                        k_next = k_reg + 2'd1;
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LB) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (rdy) state_next = S_MEMWB;
            S_MEMWR: begin
                if (rdy) begin
                    state_next = S_FETCH;
                    k_next     = '0;
                end
            end
            S_RTYPEEX: state_next = S_RTYPEWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_MEMWB, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX, S_ILLEGAL: begin
                state_next = S_FETCH;
                k_next     = '0;
            end
            default: begin
                state_next = S_FETCH;
                k_next     = '0;
            end
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        memwrite     = 1'b0;
        iord         = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        aluop        = 2'b00;
        pcsrc        = 2'b00;
        regwrite     = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        illegal_op   = 1'b0;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        fetch_strobe = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_req      = 1'b1;
                alusrcb      = 2'b01;
                pcwrite      = rdy;
                fetch_strobe = rdy;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
        // Strobes must be quiet the moment reset asserts, not at the next edge.
        if (!reset) begin
            mem_req      = 1'b0;
            memwrite     = 1'b0;
            regwrite     = 1'b0;
            illegal_op   = 1'b0;
            pcwrite      = 1'b0;
            branch       = 1'b0;
            fetch_strobe = 1'b0;
        end
    end

    assign pcen = pcwrite | (branch & zero);

    for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_irwrite
        assign irwrite[gi] = fetch_strobe & (k_reg == 2'(gi));
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: builds the expected per-cycle output trace of each
// instruction from the control rules and compares both DUT configurations every cycle.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic [3:0] irwrite;
        logic       pcen;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       illegal_op;
    } out_t;

    logic       clk = 1'b0;
    logic       reset0 = 1'b0;
    logic       reset1 = 1'b0;
    logic [5:0] op = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    out_t       act0, act1;
    logic       irw1;

    int checks = 0;
    int fails  = 0;

    out_t q_exp[$];
    bit   q_rdy[$];
    bit   q_z[$];
    logic [5:0] cur_op;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.FETCH_BYTES(4), .OP_W(6), .MEM_HS(1)) dut0 (
        .clk(clk), .reset(reset0), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(act0.mem_req), .memwrite(act0.memwrite), .irwrite(act0.irwrite),
        .pcen(act0.pcen), .iord(act0.iord), .alusrca(act0.alusrca), .alusrcb(act0.alusrcb),
        .aluop(act0.aluop), .pcsrc(act0.pcsrc), .regwrite(act0.regwrite),
        .regdst(act0.regdst), .memtoreg(act0.memtoreg), .illegal_op(act0.illegal_op)
    );

    mips_multicycle_ctrl #(.FETCH_BYTES(1), .OP_W(6), .MEM_HS(0)) dut1 (
        .clk(clk), .reset(reset1), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(act1.mem_req), .memwrite(act1.memwrite), .irwrite(irw1),
        .pcen(act1.pcen), .iord(act1.iord), .alusrca(act1.alusrca), .alusrcb(act1.alusrcb),
        .aluop(act1.aluop), .pcsrc(act1.pcsrc), .regwrite(act1.regwrite),
        .regdst(act1.regdst), .memtoreg(act1.memtoreg), .illegal_op(act1.illegal_op)
    );
    assign act1.irwrite = {3'b000, irw1};

    function automatic bit rbit();
        return bit'($urandom % 2);
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return (o == 6'h20) || (o == 6'h28) || (o == 6'h00) || (o == 6'h04) ||
               (o == 6'h08) || (o == 6'h02);
    endfunction

    task automatic push(input out_t v, input bit r, input bit z);
        q_exp.push_back(v);
        q_rdy.push_back(r);
        q_z.push_back(z);
    endtask

    // A memory beat: with the handshake it stalls w cycles then completes; without, one cycle.
    task automatic push_mem(input out_t v, input bit hs, input int wmin, input int wmax);
        if (hs) begin
            int w = $urandom_range(wmax, wmin);
            repeat (w) push(v, 1'b0, rbit());
            push(v, 1'b1, rbit());
        end else begin
            push(v, rbit(), rbit());
        end
    endtask

    // zsel: 0/1 forces the zero flag during the branch cycle, 2 picks it randomly.
    task automatic build(input logic [5:0] opc, input int which, input int zsel,
                         input int fwmax, input int mwmin, input int mwmax);
        int   fb = (which != 0) ? 1 : 4;
        bit   hs = (which == 0);
        out_t v;
        bit   zv;
        q_exp.delete();
        q_rdy.delete();
        q_z.delete();
        cur_op = opc;
        for (int b = 0; b < fb; b++) begin
            v = '0;
            v.mem_req = 1'b1;
            v.alusrcb = 2'b01;
            if (hs) repeat ($urandom_range(fwmax, 0)) push(v, 1'b0, rbit());
            v.irwrite = 4'(1 << b);
            v.pcen    = 1'b1;
            push(v, hs ? 1'b1 : rbit(), rbit());
        end
        v = '0;
        v.alusrcb = 2'b11;
        push(v, rbit(), rbit());
        case (opc)
            6'h20, 6'h28: begin
                v = '0;
                v.alusrca = 1'b1;
                v.alusrcb = 2'b10;
                push(v, rbit(), rbit());
                v = '0;
                v.mem_req = 1'b1;
                v.iord    = 1'b1;
                if (opc == 6'h28) begin
                    v.memwrite = 1'b1;
                    push_mem(v, hs, mwmin, mwmax);
                end else begin
                    push_mem(v, hs, mwmin, mwmax);
                    v = '0;
                    v.regwrite = 1'b1;
                    v.memtoreg = 1'b1;
                    push(v, rbit(), rbit());
                end
            end
            6'h00: begin
                v = '0;
                v.alusrca = 1'b1;
                v.aluop   = 2'b10;
                push(v, rbit(), rbit());
                v = '0;
                v.regwrite = 1'b1;
                v.regdst   = 1'b1;
                push(v, rbit(), rbit());
            end
            6'h04: begin
                zv = (zsel == 2) ? rbit() : bit'(zsel);
                v = '0;
                v.alusrca = 1'b1;
                v.aluop   = 2'b01;
                v.pcsrc   = 2'b01;
                v.pcen    = zv;
                push(v, rbit(), zv);
            end
            6'h08: begin
                v = '0;
                v.alusrca = 1'b1;
                v.alusrcb = 2'b10;
                push(v, rbit(), rbit());
                v = '0;
                v.regwrite = 1'b1;
                push(v, rbit(), rbit());
            end
            6'h02: begin
                v = '0;
                v.pcsrc = 2'b10;
                v.pcen  = 1'b1;
                push(v, rbit(), rbit());
            end
            default: begin
                v = '0;
                v.illegal_op = 1'b1;
                push(v, rbit(), rbit());
            end
        endcase
    endtask

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Drives one trace entry per cycle at the falling edge, then compares 1 ns later.
    task automatic run_trace(input int which, input int last);
        int   n = (last < 0) ? q_exp.size() - 1 : last;
        out_t a;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (which != 0) reset1 = 1'b1;
            else reset0 = 1'b1;
            op        = cur_op;
            mem_ready = q_rdy[i];
            zero      = q_z[i];
            #1;
            a = (which != 0) ? act1 : act0;
            checks++;
            if (a !== q_exp[i]) begin
                fails++;
                $display("FAIL cycle dut%0d op=%h step %0d: got %h, expected %h",
                         which, cur_op, i, a, q_exp[i]);
            end
        end
    endtask

    task automatic check_quiet(input int which, input string name);
        out_t a = (which != 0) ? act1 : act0;
        check(name, int'({a.mem_req, a.memwrite, a.irwrite, a.pcen, a.regwrite, a.illegal_op}), 0);
    endtask

    task automatic do_reset(input int which);
        @(negedge clk);
        reset0    = 1'b0;
        reset1    = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #1;
        check_quiet(which, "reset_quiet");
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom % 8)
            0: o = 6'h20;
            1: o = 6'h28;
            2: o = 6'h00;
            3: o = 6'h04;
            4: o = 6'h08;
            5: o = 6'h02;
            default: begin
                o = 6'($urandom);
                while (is_legal(o)) o = 6'($urandom);
            end
        endcase
        return o;
    endfunction

    initial begin
        do_reset(0);

        build(6'h00, 0, 2, 0, 0, 0);
        check("rtype_len", q_exp.size(), 7);
        check("rtype_beat2_irwrite", int'(q_exp[2].irwrite), 4);
        check("rtype_ex_aluop", int'(q_exp[5].aluop), 2);
        run_trace(0, -1);

        build(6'h20, 0, 2, 0, 3, 3);
        check("lb_wait_len", q_exp.size(), 11);
        run_trace(0, -1);

        build(6'h04, 0, 1, 0, 0, 0);
        check("beq_len", q_exp.size(), 6);
        check("beq_z1_pcen", int'(q_exp[5].pcen), 1);
        run_trace(0, -1);
        build(6'h04, 0, 0, 1, 0, 0);
        run_trace(0, -1);

        build(6'h3F, 0, 2, 0, 0, 0);
        check("illegal_pulse", int'(q_exp[5].illegal_op), 1);
        run_trace(0, -1);

        // Abandon a store while it waits for memory.
        build(6'h28, 0, 2, 0, 3, 3);
        check("sb_wait_len", q_exp.size(), 10);
        check("sb_memwr_step", int'(q_exp[6].memwrite), 1);
        run_trace(0, 6);
        #2;
        mem_ready = 1'b0;
        reset0    = 1'b0;
        #1;
        check_quiet(0, "reset_in_memwr");
        build(6'h08, 0, 2, 2, 0, 0);
        run_trace(0, -1);

        for (int t = 0; t < 60; t++) begin
            build(rand_op(), 0, 2, 2, 0, 3);
            run_trace(0, -1);
        end

        do_reset(1);
        build(6'h02, 1, 2, 0, 0, 0);
        check("j_fb1_len", q_exp.size(), 3);
        run_trace(1, -1);
        for (int t = 0; t < 30; t++) begin
            build(rand_op(), 1, 2, 0, 0, 0);
            run_trace(1, -1);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
